// File: rtl/aes_sys_pkg.sv
// Shared constants and types for the AES byte-to-block path: SRAM geometry,
// block size and the block-buffer state encoding.
package aes_sys_pkg;

  localparam int ADDR_W    = 13;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int BLK_BYTES = 16;
  localparam int BLK_W     = 8 * BLK_BYTES;
  localparam int IDX_W     = $clog2(BLK_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    RD_LAST
  } buf_state_t;

endpackage

// File: rtl/aes_block_buffer.sv
// Byte stream in, 128-bit blocks out, using an external single-port 8-bit SRAM
// as the FIFO store. Bursts of BLK_BYTES reads assemble one block at a time.
module aes_block_buffer
  import aes_sys_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [BLK_W-1:0]    blk_data,
  output logic [ADDR_W:0]     level,
  output logic                ram_ce,
  output logic                ram_oce,
  output logic                ram_wre,
  output logic [ADDR_W-1:0]   ram_ad,
  output logic [7:0]          ram_din,
  input  logic [7:0]          ram_dout
);

  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  BLK_L     = (ADDR_W + 1)'(BLK_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BLK_BYTES - 1);

  buf_state_t                 state, state_nxt;
  logic [ADDR_W-1:0]          wr_ptr, rd_ptr;
  logic [ADDR_W:0]            level_q;
  logic [IDX_W-1:0]           idx;
  logic [8*(BLK_BYTES-1)-1:0] shreg;
  logic                       flush, wr_fire, rd_fire;

  // A flush cycle suppresses every SRAM access so no stray write lands.
  assign flush = !reset_n || clear;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = (level_q < DEPTH_L);
        wr_fire  = in_valid && in_ready && !flush;
        if (level_q >= BLK_L && !blk_valid) state_nxt = RD;
      end
      RD: begin
        rd_fire = !flush;
        if (idx == IDX_LAST) state_nxt = RD_LAST;
      end
      RD_LAST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ram_ce  = wr_fire || rd_fire;
  assign ram_oce = ram_ce;
  assign ram_wre = wr_fire;
  assign ram_ad  = rd_fire ? rd_ptr : (wr_fire ? wr_ptr : '0);
  assign ram_din = wr_fire ? in_data : 8'h00;
  assign level   = level_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      idx       <= '0;
      blk_valid <= 1'b0;
      blk_data  <= '0;
    end else begin
      state <= state_nxt;
      if (wr_fire) begin
        wr_ptr  <= wr_ptr + 1'b1;
        level_q <= level_q + 1'b1;
      end else if (rd_fire) begin
        rd_ptr  <= rd_ptr + 1'b1;
        level_q <= level_q - 1'b1;
        idx     <= idx + 1'b1;
      end
      if (state == RD_LAST) begin
        blk_valid <= 1'b1;
        blk_data  <= {shreg, ram_dout};
      end else if (blk_valid && blk_ready) begin
        blk_valid <= 1'b0;
      end
    end
  end

  // NOTE: the assembly shift register is pure datapath and needs no reset;
  // a flush abandons the burst, so stale contents are never loaded.
  always_ff @(posedge clk) begin
    if (state == RD && idx != '0) shreg <= {shreg[8*(BLK_BYTES-2)-1:0], ram_dout};
  end

endmodule

// File: tb/tb_aes_block_buffer.sv
// Self-checking bench for aes_block_buffer with a behavioural 1-cycle SRAM and a
// byte scoreboard that predicts every delivered block.
module tb_aes_block_buffer;

  logic         clk = 1'b0;
  logic         reset_n, clear, in_valid, in_ready, blk_valid, blk_ready;
  logic [7:0]   in_data, ram_din, ram_dout;
  logic [127:0] blk_data;
  logic [13:0]  level;
  logic         ram_ce, ram_oce, ram_wre;
  logic [12:0]  ram_ad;

  logic [7:0]   mem [8192];
  logic [7:0]   byte_q [$];
  int           n_checks = 0;
  int           n_err = 0;
  int           blk_count = 0;

  always #5 clk = ~clk;

  aes_block_buffer dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .level(level),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Single-port SRAM, write-normal: the written byte also appears on dout.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) begin
        mem[ram_ad] <= ram_din;
        ram_dout    <= ram_din;
      end else begin
        ram_dout    <= mem[ram_ad];
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_blk(input logic [7:0] base);
    logic [127:0] b = '0;
    for (int i = 0; i < 16; i++) b = {b[119:0], 8'(base + 8'(i))};
    return b;
  endfunction

  // Scoreboard: accepted bytes queued in order, each consumed block pops 16.
  always @(negedge clk) begin
    logic [127:0] exp;
    if (!reset_n || clear) begin
      byte_q.delete();
    end else begin
      if (in_valid && in_ready) byte_q.push_back(in_data);
      if (blk_valid && blk_ready) begin
        if (byte_q.size() < 16) begin
          check("blk_underflow", 128'(byte_q.size()), 128'd16);
        end else begin
          exp = '0;
          for (int i = 0; i < 16; i++) exp = {exp[119:0], byte_q.pop_front()};
          check("blk_data_sb", blk_data, exp);
        end
        blk_count++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit rnd);
    int  waited = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!done) begin
      if (rnd) blk_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = in_ready;
      next_cycle();
      waited++;
      if (!done && waited > 200) begin
        $display("FAIL push_timeout: observed in_ready low for %0d cycles, required <= 200", waited);
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "input stalled");
      end
    end
    in_valid = 1'b0;
  endtask

  // Counts cycles (and in_ready-low cycles) from now until blk_valid is seen.
  task automatic wait_blk(output int lat, output int low);
    lat = 0;
    low = 0;
    forever begin
      @(negedge clk);
      if (blk_valid || lat >= 200) break;
      if (!in_ready) low++;
      next_cycle();
      lat++;
    end
  endtask

  initial begin
    int lat, low, base_cnt, guard;

    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; blk_ready = 1'b0;

    // 1. Reset
    repeat (2) next_cycle();
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_level",     level,     14'd0);
    check("rst_ram_ce",    ram_ce,    1'b0);
    check("rst_ram_wre",   ram_wre,   1'b0);
    reset_n = 1'b1;
    next_cycle();

    // 2. Single block, latency measured from the cycle the burst condition holds
    blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
    wait_blk(lat, low);
    check("single_latency",   lat,      32'd18);
    check("single_ready_low", low,      32'd17);
    check("single_blk_data",  blk_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("single_level",     level,    14'd0);
    next_cycle();

    // 3. Backpressure
    blk_ready = 1'b0;
    for (int i = 0; i < 32; i++) push_byte(8'(i), 1'b0);
    repeat (3) next_cycle();
    check("bp_valid",  blk_valid, 1'b1);
    check("bp_data",   blk_data,  mk_blk(8'h00));
    check("bp_level",  level,     14'd16);
    repeat (5) next_cycle();
    check("bp_hold",   blk_data,  mk_blk(8'h00));
    blk_ready = 1'b1;
    @(negedge clk);
    next_cycle();
    blk_ready = 1'b0;
    wait_blk(lat, low);
    check("bp_latency", lat,      32'd18);
    check("bp_data2",   blk_data, mk_blk(8'h10));
    next_cycle();
    blk_ready = 1'b1;
    @(negedge clk);
    next_cycle();

    // 4. Full
    blk_ready = 1'b0;
    for (int i = 0; i < 8208; i++) push_byte(8'(i), 1'b0);
    check("full_level",    level,    14'd8192);
    check("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_no_wre",   ram_wre,  1'b0);
      check("full_no_ready", in_ready, 1'b0);
      next_cycle();
    end
    in_valid = 1'b0;
    check("full_level_hold", level,    14'd8192);
    check("full_blk0",       blk_data, mk_blk(8'h00));
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    check("clr_level",    level,     14'd0);
    check("clr_valid",    blk_valid, 1'b0);
    check("clr_in_ready", in_ready,  1'b1);

    // 5. Wrap: 20000 bytes cross the 8191->0 boundary twice
    base_cnt = blk_count;
    for (int i = 0; i < 20000; i++) push_byte(8'(i), 1'b1);
    blk_ready = 1'b1;
    guard = 0;
    while (!(level == 14'd0 && !blk_valid && in_ready) && guard < 3000) begin
      next_cycle();
      guard++;
    end
    check("wrap_drain_time", 32'(guard < 3000), 32'd1);
    check("wrap_blocks",     blk_count - base_cnt, 32'd1250);
    check("wrap_level",      level, 14'd0);

    // 6. Clear at RD idx 7, then a fresh block
    for (int i = 0; i < 16; i++) push_byte(8'(i + 8'h80), 1'b0);
    repeat (8) next_cycle();
    check("mid_level",    level,    14'd9);
    check("mid_in_ready", in_ready, 1'b0);
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    check("midclr_level",    level,     14'd0);
    check("midclr_valid",    blk_valid, 1'b0);
    check("midclr_in_ready", in_ready,  1'b1);
    check("midclr_ram_ce",   ram_ce,    1'b0);
    repeat (20) next_cycle();
    check("midclr_no_blk",   blk_valid, 1'b0);
    for (int i = 0; i < 16; i++) push_byte(8'(i + 8'hA0), 1'b0);
    wait_blk(lat, low);
    check("fresh_latency", lat,      32'd18);
    check("fresh_data",    blk_data, mk_blk(8'hA0));
    next_cycle();
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
